// File: rtl/nf_wb_pkg.sv
// Shared types for the register-file writeback arbiter and its ALU hold buffer.
package nf_wb_pkg;

  localparam logic [4:0] NF_RF_ZERO = 5'd0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_req_t;

endpackage

// File: rtl/nf_wb_fifo.sv
// In-order hold buffer for ALU writebacks; exposes all entries oldest-first so the
// arbiter can bypass from them.
module nf_wb_fifo
  import nf_wb_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push_i,
  input  wb_req_t              push_req_i,
  input  logic                 pop_i,
  output wb_req_t              head_o,
  output logic                 full_o,
  output logic                 empty_o,
  output wb_req_t              ent_o [BUF_DEPTH],
  output logic [BUF_DEPTH-1:0] vld_o
);

  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

  wb_req_t            mem_q [BUF_DEPTH];
  wb_req_t            mem_d [BUF_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CNT_W'(BUF_DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // NOTE: combinational blocks use blocking '=' and assign every output a default
  // first, so no latch is inferred; state registers below use non-blocking '<='.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_req_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
  end

  always_comb begin
    for (int i = 0; i < int'(BUF_DEPTH); i++) begin
      ent_o[i] = mem_q[PTR_W'((int'(rd_ptr_q) + i) % int'(BUF_DEPTH))];
      vld_o[i] = (i < int'(cnt_q));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: payload storage is deliberately not reset; cnt_q alone decides which
  // entries are valid, so clearing the data would only cost reset fan-out.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  push_when_full: assert property (@(posedge clk) disable iff (reset) !(push_i && full_o));

endmodule

// File: rtl/nf_rf_wb_arb.sv
// Arbitrates the register-file write port between LSU and ALU writebacks, tracks
// outstanding loads and forwards in-flight results to decode.
module nf_rf_wb_arb
  import nf_wb_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_vld,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_rdy,
  input  logic        lsu_vld,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  input  logic        ld_issue_vld,
  input  logic [4:0]  ld_issue_rd,
  input  logic [4:0]  dec_ra1,
  input  logic [4:0]  dec_ra2,
  input  logic [4:0]  dec_rd,
  input  logic [31:0] rf_rd1,
  input  logic [31:0] rf_rd2,
  output logic [31:0] op_rd1,
  output logic [31:0] op_rd2,
  output logic        hz_stall,
  output logic [4:0]  wa3,
  output logic [31:0] wd3,
  output logic        we3
);

  wb_req_t              head, sel_req;
  wb_req_t              buf_ent [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] buf_vld;
  logic                 buf_full, buf_empty;
  logic                 alu_acc, push, pop, sel_vld, buf_hit;
  logic [31:0]          busy_q, busy_d, busy_eff, clr_mask;

  assign alu_rdy = ~buf_full;
  assign alu_acc = alu_vld & alu_rdy;
  assign push    = alu_acc & (lsu_vld | ~buf_empty);
  assign pop     = ~lsu_vld & ~buf_empty;

  nf_wb_fifo #(.BUF_DEPTH(BUF_DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push),
    .push_req_i ('{rd: alu_rd, data: alu_data}),
    .pop_i      (pop),
    .head_o     (head),
    .full_o     (buf_full),
    .empty_o    (buf_empty),
    .ent_o      (buf_ent),
    .vld_o      (buf_vld)
  );

  always_comb begin
    sel_vld = 1'b0;
    sel_req = '0;
    if (lsu_vld) begin
      sel_vld = 1'b1;
      sel_req = '{rd: lsu_rd, data: lsu_data};
    end else if (!buf_empty) begin
      sel_vld = 1'b1;
      sel_req = head;
    end else if (alu_acc) begin
      sel_vld = 1'b1;
      sel_req = '{rd: alu_rd, data: alu_data};
    end
    // x0 writes still consume their turn but never reach the register file
    we3 = sel_vld && (sel_req.rd != NF_RF_ZERO);
    wa3 = we3 ? sel_req.rd : NF_RF_ZERO;
    wd3 = we3 ? sel_req.data : '0;
  end

  // Set is applied after clear so a same-cycle issue of the same register wins.
  always_comb begin
    clr_mask = lsu_vld ? (32'd1 << lsu_rd) : '0;
    busy_d   = busy_q & ~clr_mask;
    if (ld_issue_vld && ld_issue_rd != NF_RF_ZERO) busy_d[ld_issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  // A load returning this cycle no longer blocks decode: its data is bypassed.
  assign busy_eff = busy_q & ~clr_mask;

  always_comb begin
    buf_hit = 1'b0;
    op_rd1  = (we3 && wa3 == dec_ra1) ? wd3 : rf_rd1;
    op_rd2  = (we3 && wa3 == dec_ra2) ? wd3 : rf_rd2;
    for (int i = 0; i < int'(BUF_DEPTH); i++) begin
      // entries are oldest-first, so later hits are younger and override
      if (buf_vld[i] && buf_ent[i].rd == dec_ra1) op_rd1 = buf_ent[i].data;
      if (buf_vld[i] && buf_ent[i].rd == dec_ra2) op_rd2 = buf_ent[i].data;
      if (buf_vld[i] && buf_ent[i].rd == dec_rd && dec_rd != NF_RF_ZERO) buf_hit = 1'b1;
    end
    if (dec_ra1 == NF_RF_ZERO) op_rd1 = '0;
    if (dec_ra2 == NF_RF_ZERO) op_rd2 = '0;
    hz_stall = busy_eff[dec_ra1] | busy_eff[dec_ra2] | busy_eff[dec_rd] | buf_hit;
  end

endmodule

// File: tb/tb_nf_rf_wb_arb.sv
// Directed bench for nf_rf_wb_arb: writeback arbitration, hold buffer, scoreboard,
// forwarding and mid-run reset, with hand-computed expectations.
module tb_nf_rf_wb_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_vld, alu_rdy, lsu_vld, ld_issue_vld;
  logic [4:0]  alu_rd, lsu_rd, ld_issue_rd, dec_ra1, dec_ra2, dec_rd, wa3;
  logic [31:0] alu_data, lsu_data, rf_rd1, rf_rd2, op_rd1, op_rd2, wd3;
  logic        hz_stall, we3;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  nf_rf_wb_arb #(.BUF_DEPTH(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .alu_vld      (alu_vld),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .alu_rdy      (alu_rdy),
    .lsu_vld      (lsu_vld),
    .lsu_rd       (lsu_rd),
    .lsu_data     (lsu_data),
    .ld_issue_vld (ld_issue_vld),
    .ld_issue_rd  (ld_issue_rd),
    .dec_ra1      (dec_ra1),
    .dec_ra2      (dec_ra2),
    .dec_rd       (dec_rd),
    .rf_rd1       (rf_rd1),
    .rf_rd2       (rf_rd2),
    .op_rd1       (op_rd1),
    .op_rd2       (op_rd2),
    .hz_stall     (hz_stall),
    .wa3          (wa3),
    .wd3          (wd3),
    .we3          (we3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    alu_vld = 0; alu_rd = 0; alu_data = 0;
    lsu_vld = 0; lsu_rd = 0; lsu_data = 0;
    ld_issue_vld = 0; ld_issue_rd = 0;
    dec_ra1 = 0; dec_ra2 = 0; dec_rd = 0;
    rf_rd1 = 32'hDEAD_0001; rf_rd2 = 32'hDEAD_0002;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] d);
    alu_vld = 1; alu_rd = rd; alu_data = d;
  endtask

  task automatic lsu(input logic [4:0] rd, input logic [31:0] d);
    lsu_vld = 1; lsu_rd = rd; lsu_data = d;
  endtask

  task automatic wr(input string tag, input logic e, input logic [4:0] a, input logic [31:0] d);
    check({tag, ".we3"}, 32'(we3), 32'(e));
    check({tag, ".wa3"}, 32'(wa3), 32'(a));
    check({tag, ".wd3"}, wd3, d);
  endtask

  // Advance to just after the next rising edge; inputs are then driven and
  // outputs checked a few ns later, well clear of either edge.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1;
    idle();
    #2;
    wr("reset", 0, 0, 0);
    check("reset.alu_rdy", 32'(alu_rdy), 1);
    check("reset.hz_stall", 32'(hz_stall), 0);
    next();
    reset = 0;

    // ALU-only write goes straight through
    alu(5, 32'h11); #3;
    wr("alu_direct", 1, 5, 32'h11);
    check("alu_direct.rdy", 32'(alu_rdy), 1);
    next(); idle();

    // LSU wins the collision; ALU result follows next cycle from the buffer
    lsu(3, 32'hAA); alu(4, 32'hBB); #3;
    wr("coll.c0", 1, 3, 32'hAA);
    next(); idle();
    dec_ra1 = 4; dec_rd = 4; #3;
    wr("coll.c1", 1, 4, 32'hBB);
    check("coll.c1.rdy", 32'(alu_rdy), 1);
    check("coll.c1.fwd", op_rd1, 32'hBB);
    check("coll.c1.hz_rd", 32'(hz_stall), 1);
    next(); idle(); #3;
    wr("coll.c2", 0, 0, 0);
    next();

    // Three LSU cycles with ALU pressure: buffer fills, then drains in order
    lsu(10, 32'h100); alu(11, 32'h201); #3;
    wr("fill.a", 1, 10, 32'h100);
    next(); idle();
    lsu(12, 32'h102); alu(13, 32'h203); #3;
    wr("fill.b", 1, 12, 32'h102);
    check("fill.b.rdy", 32'(alu_rdy), 1);
    next(); idle();
    lsu(14, 32'h104); alu(15, 32'h205); dec_ra2 = 13; #3;
    wr("fill.c", 1, 14, 32'h104);
    check("fill.c.rdy", 32'(alu_rdy), 0);
    check("fill.c.fwd", op_rd2, 32'h203);
    next(); idle();
    alu(15, 32'h205); #3;
    wr("drain.d", 1, 11, 32'h201);
    check("drain.d.rdy", 32'(alu_rdy), 0);
    next(); idle();
    alu(15, 32'h205); #3;
    wr("drain.e", 1, 13, 32'h203);
    check("drain.e.rdy", 32'(alu_rdy), 1);
    next(); idle(); #3;
    wr("drain.f", 1, 15, 32'h205);
    next(); idle(); #3;
    wr("drain.g", 0, 0, 0);
    next();

    // Load scoreboard: stall until the load returns, then bypass its data
    ld_issue_vld = 1; ld_issue_rd = 7; #3;
    check("ld7.issue.hz", 32'(hz_stall), 0);
    next(); idle();
    dec_ra1 = 7; #3;
    check("ld7.wait1.hz", 32'(hz_stall), 1);
    next(); idle();
    dec_ra1 = 7; #3;
    check("ld7.wait2.hz", 32'(hz_stall), 1);
    next(); idle();
    dec_ra1 = 7; lsu(7, 32'h55); #3;
    check("ld7.ret.hz", 32'(hz_stall), 0);
    check("ld7.ret.op1", op_rd1, 32'h55);
    next(); idle();
    dec_ra1 = 7; rf_rd1 = 32'h77; #3;
    check("ld7.after.hz", 32'(hz_stall), 0);
    check("ld7.after.op1", op_rd1, 32'h77);
    next(); idle();

    // Same-cycle set and clear of one register: set wins
    ld_issue_vld = 1; ld_issue_rd = 8; #3;
    next(); idle();
    ld_issue_vld = 1; ld_issue_rd = 8; lsu(8, 32'h81); #3;
    next(); idle();
    dec_ra2 = 8; #3;
    check("ld8.setwins.hz", 32'(hz_stall), 1);
    next(); idle();
    dec_ra2 = 8; lsu(8, 32'h82); #3;
    check("ld8.ret.hz", 32'(hz_stall), 0);
    check("ld8.ret.op2", op_rd2, 32'h82);
    next(); idle();
    dec_ra2 = 8; rf_rd2 = 32'h99; #3;
    check("ld8.after.op2", op_rd2, 32'h99);
    next(); idle();

    // Writes to x0 consume a turn but never enable the register file
    alu(0, 32'h99); dec_ra2 = 0; rf_rd2 = 32'h1234; #3;
    wr("x0", 0, 0, 0);
    check("x0.rdy", 32'(alu_rdy), 1);
    check("x0.op2", op_rd2, 0);
    next(); idle();

    // Mid-run reset discards buffered entries and scoreboard bits
    lsu(1, 32'h1); alu(2, 32'h2); ld_issue_vld = 1; ld_issue_rd = 9; #3;
    next(); idle();
    lsu(1, 32'h3); alu(6, 32'h6); #3;
    next(); idle();
    dec_ra1 = 9; #3;
    check("prerst.rdy", 32'(alu_rdy), 0);
    check("prerst.hz", 32'(hz_stall), 1);
    wr("prerst", 1, 2, 32'h2);
    reset = 1; #1;
    wr("rst", 0, 0, 0);
    check("rst.rdy", 32'(alu_rdy), 1);
    check("rst.hz", 32'(hz_stall), 0);
    next();
    reset = 0; #3;
    wr("postrst", 0, 0, 0);
    check("postrst.hz", 32'(hz_stall), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
